// File: rtl/spi_arb.sv
// spi_arb: round-robin share of one SPI master between inertial (0) and A2D (1) requesters, with SS_n guard gap.
// Optional watchdog abort on a stuck transaction is built when SPI_ARB_TMO_EN is defined.
module spi_arb #(
   parameter int GUARD_CYC = 4,
   parameter int TMO_CYC   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [15:0] cmd0,
   input  logic [15:0] cmd1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic        err0,
   output logic        err1,
   output logic [15:0] rd_data,
   output logic        mst_wrt,
   output logic [15:0] mst_cmd,
   input  logic        mst_done,
   input  logic [15:0] mst_rd,
   input  logic        mst_SS_n,
   output logic        mst_MISO,
   output logic        ss0_n,
   output logic        ss1_n,
   input  logic        miso0,
   input  logic        miso1,
   output logic        busy
);

   localparam int GW = $clog2(GUARD_CYC + 1);

   if (GUARD_CYC < 1 || TMO_CYC < 2) begin : g_bad_param
      $error("spi_arb: GUARD_CYC must be >= 1 and TMO_CYC >= 2");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, GUARD} state_t;

   state_t        state;
   logic          owner;
   logic          last;
   logic [GW-1:0] gcnt;
   logic          pick;

   // On a tie the requester that did not own the bus last time wins.
   assign pick = (req0 && req1) ? ~last : req1;

   assign busy     = (state != IDLE);
   assign ss0_n    = gnt0 ? mst_SS_n : 1'b1;
   assign ss1_n    = gnt1 ? mst_SS_n : 1'b1;
   assign mst_MISO = gnt0 ? miso0 : (gnt1 ? miso1 : 1'b0);

`ifdef SPI_ARB_TMO_EN
   localparam int TW = $clog2(TMO_CYC + 1);
   logic [TW-1:0] tcnt;
`else
   assign err0 = 1'b0;
   assign err1 = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         owner   <= 1'b0;
         last    <= 1'b1;
         gcnt    <= '0;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         done0   <= 1'b0;
         done1   <= 1'b0;
         mst_wrt <= 1'b0;
         mst_cmd <= '0;
         rd_data <= '0;
`ifdef SPI_ARB_TMO_EN
         err0    <= 1'b0;
         err1    <= 1'b0;
         tcnt    <= '0;
`endif
      end else begin
         done0   <= 1'b0;
         done1   <= 1'b0;
         mst_wrt <= 1'b0;
`ifdef SPI_ARB_TMO_EN
         err0    <= 1'b0;
         err1    <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  owner   <= pick;
                  last    <= pick;
                  mst_cmd <= pick ? cmd1 : cmd0;
                  gnt0    <= ~pick;
                  gnt1    <= pick;
                  mst_wrt <= 1'b1;
                  state   <= ISSUE;
`ifdef SPI_ARB_TMO_EN
                  tcnt    <= '0;
`endif
               end
            end
            ISSUE: begin
               state <= BUSY;
`ifdef SPI_ARB_TMO_EN
               tcnt  <= tcnt + TW'(1);
`endif
            end
            BUSY: begin
               if (mst_done) begin
                  rd_data <= mst_rd;
                  done0   <= ~owner;
                  done1   <= owner;
                  gnt0    <= 1'b0;
                  gnt1    <= 1'b0;
                  gcnt    <= GW'(GUARD_CYC - 1);
                  state   <= GUARD;
               end
`ifdef SPI_ARB_TMO_EN
               // Counting starts at mst_wrt, so the abort lands TMO_CYC cycles after it.
               else if (tcnt == TW'(TMO_CYC - 1)) begin
                  err0  <= ~owner;
                  err1  <= owner;
                  gnt0  <= 1'b0;
                  gnt1  <= 1'b0;
                  gcnt  <= GW'(GUARD_CYC - 1);
                  state <= GUARD;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
`endif
            end
            GUARD: begin
               if (gcnt == '0) state <= IDLE;
               else            gcnt  <= gcnt - GW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_arb.sv
// Directed and randomized checks of spi_arb against a transaction-level arbitration model.
module tb_spi_arb;
   localparam int G = 4;
   localparam int T = 16;

   logic        clk = 1'b0;
   logic        rst, req0, req1, mst_done, mst_SS_n, miso0, miso1;
   logic [15:0] cmd0, cmd1, mst_rd;
   logic        gnt0, gnt1, done0, done1, err0, err1, mst_wrt, mst_MISO, ss0_n, ss1_n, busy;
   logic [15:0] rd_data, mst_cmd;

   int checks = 0;
   int errors = 0;
   bit          last_m = 1'b1;  // requester that owned the bus most recently
   logic [15:0] rd_m   = '0;    // last completed read word

   always #5 clk = ~clk;

   spi_arb #(.GUARD_CYC(G), .TMO_CYC(T)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err0(err0), .err1(err1),
      .rd_data(rd_data), .mst_wrt(mst_wrt), .mst_cmd(mst_cmd), .mst_done(mst_done),
      .mst_rd(mst_rd), .mst_SS_n(mst_SS_n), .mst_MISO(mst_MISO), .ss0_n(ss0_n),
      .ss1_n(ss1_n), .miso0(miso0), .miso1(miso1), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction from an IDLE arbiter; requests must already be set.
   // nr0/nr1 are raised during the guard gap and must not be granted before IDLE.
   task automatic txn(input logic [15:0] rd, input int lat, input bit nr0, input bit nr1);
      bit w;
      w = (req0 && req1) ? ~last_m : req1;
      step();
      check("gnt0", gnt0, !w);
      check("gnt1", gnt1, w);
      check("mst_cmd", mst_cmd, w ? cmd1 : cmd0);
      check("mst_wrt", mst_wrt, 1);
      last_m = w;
      step();
      check("wrt_pulse", mst_wrt, 0);
      check("busy", busy, 1);
      for (int i = 0; i < lat; i++) begin
         mst_SS_n = 1'($urandom);
         miso0    = 1'($urandom);
         miso1    = 1'($urandom);
         #1;
         check("ss0_n", ss0_n, w ? 1'b1 : mst_SS_n);
         check("ss1_n", ss1_n, w ? mst_SS_n : 1'b1);
         check("mst_miso", mst_MISO, w ? miso1 : miso0);
         check("no_done", {done0, done1}, 0);
         step();
      end
      mst_SS_n = 1'b1;
      mst_done = 1'b1;
      mst_rd   = rd;
      step();
      mst_done = 1'b0;
      check("done0", done0, !w);
      check("done1", done1, w);
      check("rd_data", rd_data, rd);
      check("gnt_clr", {gnt0, gnt1}, 0);
      rd_m = rd;
      if (w) req1 = 1'b0;
      else   req0 = 1'b0;
      for (int k = 2; k <= G; k++) begin
         step();
         if (k == 2) begin
            check("done_pulse", {done0, done1}, 0);
            req0 = nr0;
            req1 = nr1;
         end
         check("guard_gnt", {gnt0, gnt1}, 0);
         check("guard_busy", busy, 1);
      end
      step();
      check("guard_end_busy", busy, 0);
      check("guard_end_gnt", {gnt0, gnt1}, 0);
   endtask

   initial begin
      rst = 1'b1; req0 = 0; req1 = 0; cmd0 = '0; cmd1 = '0; mst_done = 0; mst_rd = '0;
      mst_SS_n = 1'b0; miso0 = 1'b1; miso1 = 1'b1;
      step();
      step();
      check("rst_gnt", {gnt0, gnt1}, 0);
      check("rst_done_err", {done0, done1, err0, err1}, 0);
      check("rst_wrt", mst_wrt, 0);
      check("rst_cmd", mst_cmd, 0);
      check("rst_rd", rd_data, 0);
      check("rst_busy", busy, 0);
      check("rst_ss", {ss0_n, ss1_n}, 2'b11);
      check("rst_miso", mst_MISO, 0);
      rst = 1'b0;
      mst_SS_n = 1'b1;

      // Single inertial transaction; A2D asks during the guard and is served right after it.
      cmd0 = 16'h8F00; cmd1 = 16'h5A5A; req0 = 1'b1;
      txn(16'h1234, 3, 1'b0, 1'b1);
      txn(16'hBEEF, 2, 1'b0, 1'b0);

      // mst_done while IDLE is ignored.
      mst_done = 1'b1; mst_rd = 16'hABCD;
      step();
      mst_done = 1'b0;
      check("idle_done", {done0, done1}, 0);
      check("idle_rd", rd_data, rd_m);
      check("idle_busy", busy, 0);

      // Reset while BUSY discards the transaction.
      req0 = 1'b1;
      step();
      step();
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      step();
      rst = 1'b0; req0 = 1'b0;
      check("mrst_gnt", {gnt0, gnt1}, 0);
      check("mrst_ss", {ss0_n, ss1_n}, 2'b11);
      check("mrst_busy", busy, 0);
      check("mrst_rd", rd_data, 0);
      check("mrst_done", {done0, done1}, 0);
      step();
      check("mrst_done2", {done0, done1}, 0);
      last_m = 1'b1; rd_m = '0;

      // Simultaneous requests after reset: 0 first, then strict alternation.
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cmd0 = 16'($urandom); cmd1 = 16'($urandom);
         txn(16'($urandom), 1 + i, 1'b1, 1'b1);
         check("alt_owner", {31'd0, last_m}, i % 2);
      end

      // Randomized traffic.
      for (int i = 0; i < 24; i++) begin
         bit a, b;
         a = 1'($urandom); b = 1'($urandom);
         if (!a && !b) a = 1'b1;
         cmd0 = 16'($urandom); cmd1 = 16'($urandom);
         txn(16'($urandom), int'($urandom_range(1, 6)), a, b);
      end
      req0 = 1'b0; req1 = 1'b0;
      step();

      // Withheld mst_done.
      cmd0 = 16'h0F0F; req0 = 1'b1;
      step();
      check("tmo_gnt", gnt0, 1);
      check("tmo_wrt", mst_wrt, 1);
      for (int i = 1; i < T; i++) begin
         step();
         check("tmo_early_err", {err0, err1}, 0);
      end
      step();
`ifdef SPI_ARB_TMO_EN
      check("tmo_err0", err0, 1);
      check("tmo_err1", err1, 0);
      check("tmo_no_done", {done0, done1}, 0);
      check("tmo_gnt_clr", gnt0, 0);
      check("tmo_rd_keep", rd_data, rd_m);
      req0 = 1'b0;
      for (int i = 0; i < G; i++) step();
      check("tmo_idle", busy, 0);
`else
      for (int i = 0; i < 40; i++) step();
      check("hang_busy", busy, 1);
      check("hang_gnt", gnt0, 1);
      check("hang_err", {err0, err1}, 0);
      rst = 1'b1; req0 = 1'b0;
      step();
      rst = 1'b0;
      check("hang_rst", busy, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
